// File: rtl/sd_clk_divider.sv
// SD card clock divider: warm-up, divided/bypass SD clock, glitch-free stop.
// Ports: clk_i/rst_i, int_clk_en_i, sd_clk_en_i, div_i, pause_i in;
//        sd_clk_o, pos_edge_o, neg_edge_o, stable_o, running_o out.
module sd_clk_divider #(
  parameter int DIV_WIDTH     = 10,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 int_clk_en_i,
  input  logic                 sd_clk_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 pause_i,
  output logic                 sd_clk_o,
  output logic                 pos_edge_o,
  output logic                 neg_edge_o,
  output logic                 stable_o,
  output logic                 running_o
);

  localparam int WW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    READY,
    RUN,
    PAUSED
  } state_e;

  state_e               state_q, state_d;
  state_e               exit_st;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] last_cnt;
  logic                 phase_q, phase_d;
  logic                 bypass;
  logic                 wrap;
  logic                 stop_req;
  logic                 in_run;

  assign last_cnt = div_q - DIV_WIDTH'(1);
  assign bypass   = (div_q == '0);
  assign wrap     = (cnt_q == last_cnt);
  assign stop_req = !sd_clk_en_i || pause_i;
  assign in_run   = (state_q == RUN);

  // Disable wins over pause when leaving RUN.
  assign exit_st  = (pause_i && sd_clk_en_i) ? PAUSED : READY;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    div_d   = div_q;

    if (state_q inside {IDLE, WARMUP, READY}) begin
      div_d = div_i;
    end

    if (!int_clk_en_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The IDLE cycle counts as the first warm-up cycle.
          state_d = WARMUP;
          wcnt_d  = WW'(1);
        end
        WARMUP: begin
          if (wcnt_q >= WW'(STABLE_CYCLES - 1)) begin
            state_d = READY;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
        READY: begin
          if (sd_clk_en_i && !pause_i) begin
            state_d = RUN;
            cnt_d   = '0;
            phase_d = 1'b1;
          end
        end
        RUN: begin
          if (bypass) begin
            if (stop_req) begin
              state_d = exit_st;
            end
          end else begin
            if (wrap) begin
              cnt_d   = '0;
              phase_d = !phase_q;
            end else begin
              cnt_d = cnt_q + DIV_WIDTH'(1);
            end
            // Only stop on an edge that leaves the clock high,
            // so the low half-period is never cut short.
            if (stop_req && (phase_q || wrap)) begin
              state_d = exit_st;
              cnt_d   = '0;
              phase_d = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!sd_clk_en_i) begin
            state_d = READY;
          end else if (!pause_i) begin
            state_d = RUN;
            cnt_d   = '0;
            phase_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          wcnt_d  = '0;
          cnt_d   = '0;
          phase_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      div_q   <= div_d;
    end
  end

  // Bypass gates clk_i straight through while running.
  assign sd_clk_o   = in_run ? (bypass ? clk_i : phase_q) : 1'b1;
  assign pos_edge_o = in_run && (bypass || (wrap && !phase_q));
  assign neg_edge_o = in_run && !bypass && wrap && phase_q;
  assign stable_o   = (state_q inside {READY, RUN, PAUSED});
  assign running_o  = in_run;

endmodule

// File: tb/tb_sd_clk_divider.sv
// Directed self-checking bench for sd_clk_divider.
// Linear stimulus; immediate assertions at each check point.
module tb_sd_clk_divider;

  logic       clk;
  logic       rst;
  logic       int_en;
  logic       sd_en;
  logic [9:0] div;
  logic       pause;
  logic       sd_clk;
  logic       pos_e;
  logic       neg_e;
  logic       stable;
  logic       running;

  int checks = 0;
  int errors = 0;

  sd_clk_divider #(
    .DIV_WIDTH    (10),
    .STABLE_CYCLES(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .int_clk_en_i(int_en),
    .sd_clk_en_i (sd_en),
    .div_i       (div),
    .pause_i     (pause),
    .sd_clk_o    (sd_clk),
    .pos_edge_o  (pos_e),
    .neg_edge_o  (neg_e),
    .stable_o    (stable),
    .running_o   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // k counts cycles since RUN entry; high for n, low for n.
  task automatic check_run(input int n,
                           input int cycles,
                           input string tag);
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "_sd"}, 32'(sd_clk),
          32'((k / n) % 2 == 0));
      chk({tag, "_neg"}, 32'(neg_e),
          32'(k % (2 * n) == n - 1));
      chk({tag, "_pos"}, 32'(pos_e),
          32'(k % (2 * n) == 2 * n - 1));
      step(1);
    end
  endtask

  initial begin
    rst    = 1'b1;
    int_en = 1'b0;
    sd_en  = 1'b0;
    div    = '0;
    pause  = 1'b0;
    #1;
    chk("rst_sd", 32'(sd_clk), 1);
    chk("rst_pos", 32'(pos_e), 0);
    chk("rst_neg", 32'(neg_e), 0);
    chk("rst_stable", 32'(stable), 0);
    chk("rst_run", 32'(running), 0);
    step(2);
    rst = 1'b0;

    // warm-up interrupted at cycle 10, then full warm-up
    int_en = 1'b1;
    step(10);
    chk("warm10_stable", 32'(stable), 0);
    int_en = 1'b0;
    step(1);
    chk("warm_drop_stable", 32'(stable), 0);
    int_en = 1'b1;
    step(15);
    chk("warm15_stable", 32'(stable), 0);
    step(1);
    chk("warm16_stable", 32'(stable), 1);
    chk("ready_sd", 32'(sd_clk), 1);
    chk("ready_run", 32'(running), 0);

    // divide by 3
    div   = 10'd3;
    sd_en = 1'b1;
    step(1);
    chk("div3_run", 32'(running), 1);
    check_run(3, 12, "div3");
    sd_en = 1'b0;
    step(1);
    chk("div3_stop_run", 32'(running), 0);
    chk("div3_stop_sd", 32'(sd_clk), 1);
    chk("div3_stop_stable", 32'(stable), 1);

    // divisor lock: 2 while running, 5 after re-enable
    div   = 10'd2;
    sd_en = 1'b1;
    step(1);
    div = 10'd5;
    check_run(2, 8, "lock2");
    sd_en = 1'b0;
    step(1);
    chk("lock_stop_run", 32'(running), 0);
    sd_en = 1'b1;
    step(1);
    check_run(5, 10, "lock5");
    sd_en = 1'b0;
    step(1);
    chk("lock5_stop_run", 32'(running), 0);

    // maximum divisor
    div   = 10'd1023;
    sd_en = 1'b1;
    step(1);
    check_run(1023, 2046, "max");
    chk("max_wrap_sd", 32'(sd_clk), 1);
    sd_en = 1'b0;
    step(1);
    chk("max_stop_run", 32'(running), 0);

    // pause one cycle into the low phase, div 4
    div   = 10'd4;
    sd_en = 1'b1;
    step(1);
    check_run(4, 5, "pre_pause");
    pause = 1'b1;
    chk("pause_low1", 32'(sd_clk), 0);
    chk("pause_low1_run", 32'(running), 1);
    step(1);
    chk("pause_low2", 32'(sd_clk), 0);
    step(1);
    chk("pause_low3", 32'(sd_clk), 0);
    chk("pause_low3_pos", 32'(pos_e), 1);
    step(1);
    chk("paused_sd", 32'(sd_clk), 1);
    chk("paused_run", 32'(running), 0);
    chk("paused_stable", 32'(stable), 1);
    step(3);
    chk("paused_hold_sd", 32'(sd_clk), 1);
    chk("paused_pos", 32'(pos_e), 0);
    chk("paused_neg", 32'(neg_e), 0);
    pause = 1'b0;
    step(1);
    chk("resume_run", 32'(running), 1);
    check_run(4, 8, "resume");
    pause = 1'b1;
    step(1);
    chk("pause2_run", 32'(running), 0);

    // disable beats pause: must fall to READY and reload div
    div   = 10'd2;
    sd_en = 1'b0;
    step(2);
    chk("prio_stable", 32'(stable), 1);
    pause = 1'b0;
    sd_en = 1'b1;
    step(1);
    check_run(2, 4, "prio2");
    sd_en = 1'b0;
    step(1);
    chk("prio_stop_run", 32'(running), 0);

    // bypass
    div   = 10'd0;
    sd_en = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      chk("byp_hi", 32'(sd_clk), 1);
      chk("byp_pos", 32'(pos_e), 1);
      chk("byp_neg", 32'(neg_e), 0);
      #5;
      chk("byp_lo", 32'(sd_clk), 0);
      #5;
    end

    // reset while clock low in bypass RUN
    #5;
    rst = 1'b1;
    #1;
    chk("midrst_sd", 32'(sd_clk), 1);
    chk("midrst_run", 32'(running), 0);
    chk("midrst_stable", 32'(stable), 0);
    chk("midrst_pos", 32'(pos_e), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(15);
    chk("rewarm15", 32'(stable), 0);
    step(1);
    chk("rewarm16", 32'(stable), 1);
    step(1);
    chk("rewarm_run", 32'(running), 1);

    // int clock off from RUN
    int_en = 1'b0;
    step(1);
    #5;
    chk("off_sd", 32'(sd_clk), 1);
    chk("off_stable", 32'(stable), 0);
    chk("off_run", 32'(running), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_clk_divider.md
SD_CLK_DIVIDER -- requirements
Module: sd_clk_divider

Interface
REQ-001 Parameter: DIV_WIDTH, default 10, width of the divisor field (SD Host v3 10-bit divided clock mode).
REQ-002 Parameter: STABLE_CYCLES, default 16, internal clock warm-up cycles before stable is reported.
REQ-003 clk_i  input  1  controller clock; all state is on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 int_clk_en_i  input  1  internal clock enable.
REQ-006 sd_clk_en_i  input  1  SD clock enable.
REQ-007 div_i  input  DIV_WIDTH  divisor N: 0 = bypass, otherwise SD clock period = 2N clk_i cycles.
REQ-008 pause_i  input  1  request to stop sd_clk_o temporarily (buffer full/empty).
REQ-009 sd_clk_o  output  1  SD card clock; idles high.
REQ-010 pos_edge_o  output  1  high when the next clk_i rising edge coincides with an sd_clk_o rising edge.
REQ-011 neg_edge_o  output  1  high when the next clk_i rising edge coincides with an sd_clk_o falling edge.
REQ-012 stable_o  output  1  internal clock stable.
REQ-013 running_o  output  1  high while the divided clock is toggling (state RUN).

Function
REQ-014 The FSM states SHALL be IDLE, WARMUP, READY, RUN and PAUSED.
- IDLE -> WARMUP when int_clk_en_i=1.
- WARMUP -> READY after STABLE_CYCLES consecutive cycles with int_clk_en_i=1.
- READY -> RUN when sd_clk_en_i=1 and pause_i=0.
REQ-015 If int_clk_en_i=0, the FSM SHALL go to IDLE on the next edge from any state: counters cleared, sd_clk_o=1, stable_o=0.
REQ-016 stable_o SHALL be 1 exactly in READY, RUN and PAUSED.
REQ-017 Divisor register div_q SHALL load div_i every cycle the state is IDLE, WARMUP or READY.
- div_q holds while in RUN or PAUSED; div_i changes there are ignored.
REQ-018 On entry to RUN, phase counter cnt SHALL be 0 and the phase register SHALL be 1 (sd_clk_o high).
REQ-019 For N>=1 in RUN:
- cnt increments by 1 per cycle.
- When cnt==N-1, the phase register toggles and cnt wraps to 0.
- Result: N cycles high, N cycles low, 50% duty, first falling edge N cycles after entry.
REQ-020 cnt SHALL be DIV_WIDTH bits wide and SHALL never exceed N-1. N=2^DIV_WIDTH-1 SHALL give period 2(2^DIV_WIDTH-1).
REQ-021 For N>=1, the edge strobes SHALL be combinational and valid only in RUN:
- pos_edge_o = (cnt==N-1) and phase==0.
- neg_edge_o = (cnt==N-1) and phase==1.
REQ-022 For N=0 in RUN:
- sd_clk_o = clk_i (gated pass-through).
- pos_edge_o=1 and neg_edge_o=0 every cycle.
REQ-023 Outside RUN, sd_clk_o=1 and pos_edge_o=neg_edge_o=0.
REQ-024 Glitch-free stop: when sd_clk_en_i=0 or pause_i=1 in RUN, the FSM SHALL leave RUN on the edge at which phase becomes or remains 1.
- If phase=1, it leaves on the next edge.
- If phase=0, it leaves on the completing rising edge (cnt==N-1); the low half-period is never truncated.
- Target is PAUSED if pause_i=1 and sd_clk_en_i=1, otherwise READY.
- For N=0 it leaves on the next edge.
REQ-025 PAUSED -> RUN SHALL occur when pause_i=0 and sd_clk_en_i=1, re-entering per REQ-018, so a full high half-period precedes the next falling edge.
REQ-026 PAUSED -> READY SHALL occur when sd_clk_en_i=0. sd_clk_en_i=0 SHALL take priority over pause_i.
REQ-027 running_o SHALL be 1 exactly in RUN.

Reset
REQ-028 While rst_i=1, asynchronously:
- state=IDLE, cnt=0, phase=1, div_q=0, warm-up counter=0.
- Outputs: sd_clk_o=1, pos_edge_o=0, neg_edge_o=0, stable_o=0, running_o=0.
REQ-029 Reset asserted mid-RUN SHALL force sd_clk_o=1 immediately. After release, full warm-up SHALL be repeated before stable_o=1.

Verification
REQ-030 Warm-up: int_clk_en_i=1 after reset, STABLE_CYCLES=16 -> stable_o rises exactly 16 cycles later; dropping int_clk_en_i at cycle 10 -> stable_o stays 0 and the count restarts.
REQ-031 Divide: div_i=3, sd_clk_en_i=1 -> sd_clk_o high 3 / low 3 repeating; one neg_edge_o pulse and one pos_edge_o pulse per 6 cycles, each one cycle before the matching edge.
REQ-032 Maximum divisor: div_i=1023 -> period 2046 cycles; cnt wraps at 1022, never 1023.
REQ-033 Divisor lock: div_i changed 2 -> 5 during RUN -> period stays 4. After sd_clk_en_i=0 and re-enable -> period 10.
REQ-034 Pause, div_i=4: pause_i asserted 1 cycle into the low phase -> 3 more low cycles, then sd_clk_o=1 held in PAUSED. pause_i released -> 4 high cycles before the next falling edge; no edge strobes while PAUSED.
REQ-035 Bypass and reset:
- div_i=0, RUN -> sd_clk_o follows clk_i and pos_edge_o=1 each cycle.
- rst_i pulsed mid-RUN -> all outputs at reset values immediately.
